// File: rtl/ice_uart_tx_arbiter_pkg.sv
// Shared definitions for the ICE UART transmit arbiter: FSM state encoding,
// requester-count bounds and the index-width helper used by the picker.
package ice_uart_tx_arbiter_pkg;

    localparam int unsigned ICE_ARB_MIN_REQ = 2;
    localparam int unsigned ICE_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ice_rr_pick.sv
// Combinational round-robin picker: returns the first active request after
// position ptr (wrapping), as a one-hot vector and a binary index.
module ice_rr_pick
    import ice_uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        int unsigned pos;
        logic        found;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        // Search ptr+1 .. ptr+N so the previous owner has lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/ice_uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the host UART transmitter.
// Define ICE_TX_ARB_TIMEOUT_EN to enable the mid-packet stall timeout.
module ice_uart_tx_arbiter
    import ice_uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned HOLD_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_latch,
    input  logic                 tx_empty,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned IW = idx_width(NUM_REQ);

    if (NUM_REQ < ICE_ARB_MIN_REQ || NUM_REQ > ICE_ARB_MAX_REQ) begin : g_bad_num_req
        $error("ice_uart_tx_arbiter: NUM_REQ out of range");
    end
    if (HOLD_TIMEOUT < 1) begin : g_bad_hold_timeout
        $error("ice_uart_tx_arbiter: HOLD_TIMEOUT must be at least 1");
    end

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic                 busy_d;
    logic [7:0]           tx_data_d;
    logic                 tx_latch_d;
    logic [NUM_REQ-1:0]   req_ready_d;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        pick_idx;

`ifdef ICE_TX_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(HOLD_TIMEOUT + 1);
    logic [CW-1:0] stall_q, stall_d;
    logic          timeout_d;
`else
    assign timeout_err = 1'b0;
`endif

    ice_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NUM_REQ - 1);
            gidx_q    <= '0;
            last_q    <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            tx_data   <= '0;
            tx_latch  <= 1'b0;
            req_ready <= '0;
`ifdef ICE_TX_ARB_TIMEOUT_EN
            stall_q     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            grant     <= grant_d;
            busy      <= busy_d;
            tx_data   <= tx_data_d;
            tx_latch  <= tx_latch_d;
            req_ready <= req_ready_d;
`ifdef ICE_TX_ARB_TIMEOUT_EN
            stall_q     <= stall_d;
            timeout_err <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        grant_d     = grant;
        busy_d      = busy;
        tx_data_d   = tx_data;
        tx_latch_d  = 1'b0;
        req_ready_d = '0;
`ifdef ICE_TX_ARB_TIMEOUT_EN
        stall_d   = stall_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid && tx_empty) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    busy_d  = 1'b1;
                    state_d = LOAD;
`ifdef ICE_TX_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            LOAD: begin
                if (req_valid[gidx_q]) begin
                    tx_data_d   = req_data[{gidx_q, 3'b000} +: 8];
                    tx_latch_d  = 1'b1;
                    req_ready_d = grant;
                    last_d      = req_last[gidx_q];
                    state_d     = WAIT_START;
                end
`ifdef ICE_TX_ARB_TIMEOUT_EN
                // The cycle that would bring the count to HOLD_TIMEOUT revokes instead.
                else if (stall_q == CW'(HOLD_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = gidx_q;
                    state_d   = IDLE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            WAIT_START: begin
                if (!tx_empty) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_empty) begin
                    if (last_q) begin
                        grant_d = '0;
                        busy_d  = 1'b0;
                        ptr_d   = gidx_q;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
`ifdef ICE_TX_ARB_TIMEOUT_EN
                        stall_d = '0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ice_uart_tx_arbiter.sv
// Self-checking bench for ice_uart_tx_arbiter: requester and UART models feed
// a scoreboard of expected (grant, byte) pairs checked on every tx_latch.
module tb_ice_uart_tx_arbiter;

    localparam int NREQ = 4;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [3:0]      req_valid;
    logic [31:0]     req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic [7:0]      tx_data;
    logic            tx_latch;
    logic            tx_empty;
    logic [3:0]      grant;
    logic            busy;
    logic            timeout_err;

    int              checks = 0;
    int              errors = 0;
    exp_t            exp_q[$];
    logic [8:0]      src_q[NREQ][$];
    logic            hold_busy;
    logic [3:0]      rdy_seen;
    logic            latch_seen;
    int              ucnt;

    ice_uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .HOLD_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_latch    (tx_latch),
        .tx_empty    (tx_empty),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic l);
        src_q[r].push_back({l, d});
    endtask

    task automatic push_exp(input int r, input logic [7:0] d);
        exp_t e;
        e.g = 4'(1 << r);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_exp_drained(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_tx_empty(input logic v, input string tag);
        int n = 0;
        while (tx_empty !== v && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, tx_empty, v);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || tx_empty !== 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    // Requester model: presents queue heads, advances on an edge that sees req_ready.
    initial begin
        logic [8:0] head;
        forever begin
            @(negedge clk);
            rdy_seen = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rdy_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    head              = src_q[i][0];
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = head[7:0];
                    req_last[i]       = head[8];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    // UART model: six busy cycles per latched byte; hold_busy forces it non-empty.
    initial begin
        forever begin
            @(negedge clk);
            latch_seen = tx_latch;
            @(posedge clk);
            #1;
            if (latch_seen) ucnt = 6;
            else if (ucnt != 0) ucnt--;
            tx_empty = (ucnt == 0) && !hold_busy;
        end
    end

    // Scoreboard and per-cycle invariants.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("busy_vs_grant", busy, grant != 4'b0000);
            chk("grant_onehot", $countones(grant) <= 1, 1);
`ifndef ICE_TX_ARB_TIMEOUT_EN
            chk("timeout_tied_low", timeout_err, 0);
`endif
            if (tx_latch === 1'b1) begin
                chk("latch_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tx_data", tx_data, e.d);
                    chk("grant_at_latch", grant, e.g);
                    chk("req_ready_at_latch", req_ready, e.g);
                end
            end else begin
                chk("ready_without_latch", req_ready, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_empty  = 1'b1;
        hold_busy = 1'b0;
        ucnt      = 0;

        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_latch", tx_latch, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_timeout", timeout_err, 0);
        reset = 1'b1;

        // Single 3-byte packet on requester 0.
        push_src(0, 8'h41, 1'b0); push_exp(0, 8'h41);
        push_src(0, 8'h42, 1'b0); push_exp(0, 8'h42);
        push_src(0, 8'h43, 1'b1); push_exp(0, 8'h43);
        wait_exp_drained("t1_bytes");
        wait_tx_empty(1'b0, "t1_uart_busy");
        wait_tx_empty(1'b1, "t1_uart_done");
        chk("t1_busy_at_rise", busy, 1);
        chk("t1_grant_at_rise", grant, 4'b0001);
        @(negedge clk);
        chk("t1_busy_fall", busy, 0);
        chk("t1_grant_clear", grant, 0);
        wait_idle("t1_idle");

        // Requesters 1 and 2 valid from reset with 2-byte packets: no interleave.
        @(negedge clk);
        reset = 1'b0;
        push_src(1, 8'h11, 1'b0); push_exp(1, 8'h11);
        push_src(1, 8'h12, 1'b1); push_exp(1, 8'h12);
        push_src(2, 8'h21, 1'b0); push_exp(2, 8'h21);
        push_src(2, 8'h22, 1'b1); push_exp(2, 8'h22);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_exp_drained("t2_bytes");
        wait_idle("t2_idle");

        // All four continuously valid with 1-byte packets: order 0,1,2,3,0,1.
        @(negedge clk);
        reset = 1'b0;
        push_src(0, 8'hA0, 1'b1); push_exp(0, 8'hA0);
        push_src(1, 8'hA1, 1'b1); push_exp(1, 8'hA1);
        push_src(2, 8'hA2, 1'b1); push_exp(2, 8'hA2);
        push_src(3, 8'hA3, 1'b1); push_exp(3, 8'hA3);
        push_src(0, 8'hA4, 1'b1); push_exp(0, 8'hA4);
        push_src(1, 8'hA5, 1'b1); push_exp(1, 8'hA5);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_exp_drained("t3_bytes");
        wait_idle("t3_idle");

        // UART held busy: no grant until tx_empty rises, latch two cycles later.
        @(negedge clk);
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_tx_held", tx_empty, 0);
        push_src(3, 8'h3C, 1'b1); push_exp(3, 8'h3C);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_no_grant", grant, 0);
        end
        hold_busy = 1'b0;
        @(negedge clk);
        chk("t4_empty_rise", tx_empty, 1);
        chk("t4_grant_wait", grant, 0);
        @(negedge clk);
        chk("t4_grant", grant, 4'b1000);
        chk("t4_latch_pending", tx_latch, 0);
        @(negedge clk);
        chk("t4_latch", tx_latch, 1);
        wait_exp_drained("t4_bytes");
        wait_idle("t4_idle");

        // Reset during WAIT_DONE abandons the packet; requester 0 wins afterwards.
        push_src(2, 8'h51, 1'b0); push_exp(2, 8'h51);
        push_src(2, 8'h52, 1'b1);
        wait_exp_drained("t5_first_byte");
        wait_tx_empty(1'b0, "t5_uart_busy");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_tx_latch", tx_latch, 0);
        chk("t5_rst_tx_data", tx_data, 0);
        chk("t5_rst_req_ready", req_ready, 0);
        chk("t5_rst_timeout", timeout_err, 0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        push_src(2, 8'h61, 1'b1);
        push_src(0, 8'h60, 1'b1);
        push_exp(0, 8'h60);
        push_exp(2, 8'h61);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_exp_drained("t5_bytes");
        wait_idle("t5_idle");

        // Requester 0 stalls mid-packet while requester 1 waits.
        push_src(0, 8'h70, 1'b0); push_exp(0, 8'h70);
        push_src(1, 8'h71, 1'b1);
        wait_tx_empty(1'b0, "t6_uart_busy");
        wait_tx_empty(1'b1, "t6_uart_done");
`ifdef ICE_TX_ARB_TIMEOUT_EN
        push_exp(1, 8'h71);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("t6_no_timeout_yet", timeout_err, 0);
            chk("t6_grant_held", grant, 4'b0001);
        end
        @(negedge clk);
        chk("t6_timeout_pulse", timeout_err, 1);
        chk("t6_grant_revoked", grant, 0);
        chk("t6_busy_revoked", busy, 0);
        @(negedge clk);
        chk("t6_timeout_single", timeout_err, 0);
        chk("t6_req1_granted", grant, 4'b0010);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("t6_grant_held", grant, 4'b0001);
        end
        push_src(0, 8'h72, 1'b1); push_exp(0, 8'h72);
        push_exp(1, 8'h71);
`endif
        wait_exp_drained("t6_bytes");
        wait_idle("t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
